// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types for the hazard/forwarding unit: operand select encoding,
// the per-stage tracking record and the register address width.
package hazard_fwd_unit_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_EXMEM  = 2'b01,
    FWD_MEMWB  = 2'b10,
    FWD_WBHOLD = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // A stage can only supply a source it actually writes; x0 is never forwarded.
  function automatic logic stage_hits(input stage_t                s,
                                      input logic [REG_ADDR_W-1:0] rs,
                                      input logic                  use_rs);
    return s.valid && s.reg_write && use_rs && (rs != '0) && (s.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_match.sv
// fwd_match: per-operand dependency check against the EX, MEM and WB stages.
// Produces the priority-encoded forwarding select (youngest producer wins)
// and a separate EX-hit flag used for load-use detection.
module fwd_match
  import hazard_fwd_unit_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_use_rs,
  input  stage_t                i_ex,
  input  stage_t                i_mem,
  input  stage_t                i_wb,
  output fwd_sel_e              o_sel,
  output logic                  o_ex_hit
);

  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;
  logic w_unused_load_bits;

  assign w_hit_ex  = stage_hits(i_ex,  i_rs, i_use_rs);
  assign w_hit_mem = stage_hits(i_mem, i_rs, i_use_rs);
  assign w_hit_wb  = stage_hits(i_wb,  i_rs, i_use_rs);

  // Only the caller cares whether the EX producer is a load.
  assign w_unused_load_bits = ^{i_ex.mem_read, i_mem.mem_read, i_wb.mem_read};

  assign o_ex_hit = w_hit_ex;

  // Priority select: the most recent producer holds the freshest value.
  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_ex) begin
      o_sel = FWD_EXMEM;
    end else if (w_hit_mem) begin
      o_sel = FWD_MEMWB;
    end else if (w_hit_wb) begin
      o_sel = FWD_WBHOLD;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: tracks the EX/MEM/WB destination registers and decides,
// for the instruction in decode, either a forwarding select per operand or a
// pipeline stall.
// Build option HAZARD_FORWARD_EN: when defined, operands are forwarded and
// only load-use dependencies stall; when undefined, selects are tied to the
// register file and any in-flight dependency stalls until it retires.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_valid,
  input  logic       ex_flush,
  input  logic       ext_stall,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall
);

  stage_t   r_ex;
  stage_t   r_mem;
  stage_t   r_wb;
  stage_t   w_ex_next;
  fwd_sel_e w_sel_a;
  fwd_sel_e w_sel_b;
  logic     w_ex_hit_a;
  logic     w_ex_hit_b;
  logic     w_hazard;
  logic     w_issue;

  fwd_match u_fwd_a (
    .i_rs     (id_rs1),
    .i_use_rs (id_use_rs1),
    .i_ex     (r_ex),
    .i_mem    (r_mem),
    .i_wb     (r_wb),
    .o_sel    (w_sel_a),
    .o_ex_hit (w_ex_hit_a)
  );

  fwd_match u_fwd_b (
    .i_rs     (id_rs2),
    .i_use_rs (id_use_rs2),
    .i_ex     (r_ex),
    .i_mem    (r_mem),
    .i_wb     (r_wb),
    .o_sel    (w_sel_b),
    .o_ex_hit (w_ex_hit_b)
  );

`ifdef HAZARD_FORWARD_EN
  // A load in EX has no data yet, so a dependent decode must wait one cycle.
  assign w_hazard = r_ex.mem_read & (w_ex_hit_a | w_ex_hit_b);
`else
  // No bypass paths: any in-flight producer of a source blocks decode.
  logic w_unused_ex_hits;
  assign w_hazard = (w_sel_a != FWD_RF) | (w_sel_b != FWD_RF);
  assign w_unused_ex_hits = ^{w_ex_hit_a, w_ex_hit_b};
`endif

  // A taken branch kills decode, so it can never be the cause of a stall.
  assign stall   = id_valid & ~ex_flush & w_hazard;
  assign w_issue = id_valid & ~ex_flush & ~stall;

  // Next EX contents: the decode instruction, or a bubble when it cannot issue.
  always_comb begin
    w_ex_next = STAGE_BUBBLE;
    if (w_issue) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.rd        = id_rd;
      w_ex_next.reg_write = id_reg_write;
      w_ex_next.mem_read  = id_mem_read;
    end
  end

  // Stage tracking; frozen by an external memory stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex  <= STAGE_BUBBLE;
      r_mem <= STAGE_BUBBLE;
      r_wb  <= STAGE_BUBBLE;
    end else if (!ext_stall) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_ex_next;
    end
  end

`ifdef HAZARD_FORWARD_EN
  fwd_sel_e r_fwd_a_sel;
  fwd_sel_e r_fwd_b_sel;

  // Select travels with the instruction into EX; bubbles read the register file.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fwd_a_sel <= FWD_RF;
      r_fwd_b_sel <= FWD_RF;
    end else if (!ext_stall) begin
      r_fwd_a_sel <= w_issue ? w_sel_a : FWD_RF;
      r_fwd_b_sel <= w_issue ? w_sel_b : FWD_RF;
    end
  end

  assign fwd_a_sel = r_fwd_a_sel;
  assign fwd_b_sel = r_fwd_b_sel;
`else
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit. A pipeline-history model (arrays indexed
// by stage age) predicts stall and selects every cycle; per-scenario literal
// expectations pin stall counts and selects for the active build option.
module tb_hazard_fwd_unit;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, id_valid = 1'b0;
  logic       ex_flush = 1'b0, ext_stall = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_valid     (id_valid),
    .ex_flush     (ex_flush),
    .ext_stall    (ext_stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Model: index 0 = youngest in-flight instruction (EX), 1 = MEM, 2 = WB.
  bit       m_v  [3];
  bit [4:0] m_rd [3];
  bit       m_wr [3];
  bit       m_ld [3];
  bit [1:0] m_sel_a = 2'd0;
  bit [1:0] m_sel_b = 2'd0;
  bit       m_ready = 1'b0;

  function automatic bit m_hit(int k, bit [4:0] rs, bit use_rs);
    return m_v[k] && m_wr[k] && use_rs && (rs != 5'd0) && (m_rd[k] == rs);
  endfunction

  // Age k+1 doubles as the select code: EX=1, MEM=2, WB=3, none=0.
  function automatic bit [1:0] m_pick(bit [4:0] rs, bit use_rs);
    for (int k = 0; k < 3; k++) begin
      if (m_hit(k, rs, use_rs)) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  function automatic bit m_stall();
    bit load_dep;
    bit any_dep;
    if (!id_valid || ex_flush) return 1'b0;
    load_dep = m_ld[0] && (m_hit(0, id_rs1, id_use_rs1) || m_hit(0, id_rs2, id_use_rs2));
    any_dep  = (m_pick(id_rs1, id_use_rs1) != 2'd0) || (m_pick(id_rs2, id_use_rs2) != 2'd0);
    return FWD ? load_dep : any_dep;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) m_v[k] = 1'b0;
      m_sel_a = 2'd0;
      m_sel_b = 2'd0;
      m_ready = 1'b1;
    end else if (!ext_stall) begin
      bit take;
      take = id_valid && !ex_flush && !m_stall();
      m_sel_a = (FWD && take) ? m_pick(id_rs1, id_use_rs1) : 2'd0;
      m_sel_b = (FWD && take) ? m_pick(id_rs2, id_use_rs2) : 2'd0;
      for (int k = 2; k > 0; k--) begin
        m_v[k]  = m_v[k-1];
        m_rd[k] = m_rd[k-1];
        m_wr[k] = m_wr[k-1];
        m_ld[k] = m_ld[k-1];
      end
      m_v[0]  = take;
      m_rd[0] = id_rd;
      m_wr[0] = id_reg_write;
      m_ld[0] = id_mem_read;
    end
  end

  task automatic check(string name, logic [1:0] act, logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model compare on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (m_ready) begin
      check("model_stall", {1'b0, stall}, {1'b0, m_stall()});
      check("model_fwd_a", fwd_a_sel, m_sel_a);
      check("model_fwd_b", fwd_b_sel, m_sel_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                       bit [4:0] rd, bit wr, bit ld);
    id_valid = v;  id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd;    id_reg_write = wr; id_mem_read = ld;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nops(int n);
    idle();
    repeat (n) step();
  endtask

  // Presents an instruction until it issues; reports stall cycles seen.
  task automatic issue(input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                       input bit u2, input bit [4:0] rd, input bit wr, input bit ld,
                       output int stalls);
    bit s;
    bit done;
    drive(1, rs1, u1, rs2, u2, rd, wr, ld);
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      #1;
      if (s) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL issue_timeout: stall held for %0d cycles, expected release", stalls);
    end
    idle();
  endtask

  task automatic lit(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    reset = 1'b0;
    repeat (2) step();
    lit("reset_fwd_a", fwd_a_sel, 0);
    lit("reset_fwd_b", fwd_b_sel, 0);
    lit("reset_stall", stall, 0);
    reset = 1'b1;
    step();

    // Back-to-back ALU dependency on x5.
    issue(0, 0, 0, 0, 5, 1, 0, st);
    lit("b2b_producer_stalls", st, 0);
    issue(5, 1, 6, 1, 10, 1, 0, st);
    lit("b2b_stalls", st, FWD ? 0 : 3);
    lit("b2b_fwd_a", fwd_a_sel, FWD ? 1 : 0);
    lit("b2b_fwd_b", fwd_b_sel, 0);
    step();
    lit("b2b_fwd_a_one_cycle", fwd_a_sel, 0);
    nops(3);

    // One-gap dependency on x7 through rs2.
    issue(0, 0, 0, 0, 7, 1, 0, st);
    issue(0, 0, 0, 0, 1, 1, 0, st);
    issue(2, 1, 7, 1, 14, 1, 0, st);
    lit("gap_stalls", st, FWD ? 0 : 2);
    lit("gap_fwd_b", fwd_b_sel, FWD ? 2 : 0);
    nops(3);

    // Load-use on x3.
    issue(0, 0, 0, 0, 3, 1, 1, st);
    issue(3, 1, 0, 0, 15, 1, 0, st);
    lit("lu_stalls", st, FWD ? 1 : 3);
    lit("lu_fwd_a", fwd_a_sel, FWD ? 2 : 0);
    nops(3);

    // x0 is never a dependency.
    issue(0, 0, 0, 0, 0, 1, 0, st);
    issue(0, 1, 0, 1, 16, 1, 0, st);
    lit("x0_stalls", st, 0);
    lit("x0_fwd_a", fwd_a_sel, 0);
    nops(3);

    // x9 in EX and MEM at once: youngest producer wins.
    issue(0, 0, 0, 0, 9, 1, 0, st);
    issue(0, 0, 0, 0, 9, 1, 0, st);
    issue(9, 1, 0, 0, 17, 1, 0, st);
    lit("prio_stalls", st, FWD ? 0 : 3);
    lit("prio_fwd_a", fwd_a_sel, FWD ? 1 : 0);
    nops(3);

    // Flush during a load-use cycle kills the decode instruction.
    issue(0, 0, 0, 0, 3, 1, 1, st);
    drive(1, 3, 1, 0, 0, 4, 1, 0);
    ex_flush = 1'b1;
    @(negedge clk);
    lit("flush_stall", stall, 0);
    step();
    ex_flush = 1'b0;
    issue(0, 0, 4, 1, 11, 1, 0, st);
    lit("flush_bubble_stalls", st, 0);
    lit("flush_bubble_fwd_b", fwd_b_sel, 0);
    nops(3);

    // External stall freezes a pending load-use.
    issue(0, 0, 0, 0, 8, 1, 1, st);
    drive(1, 8, 1, 0, 0, 12, 1, 0);
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit("ext_stall_held", stall, 1);
      step();
    end
    ext_stall = 1'b0;
    issue(8, 1, 0, 0, 12, 1, 0, st);
    lit("ext_stall_resume_stalls", st, FWD ? 1 : 3);
    lit("ext_stall_fwd_a", fwd_a_sel, FWD ? 2 : 0);
    nops(3);

    // A non-writing producer is not a dependency.
    issue(0, 0, 0, 0, 5, 0, 0, st);
    issue(5, 1, 0, 0, 18, 1, 0, st);
    lit("nowrite_stalls", st, 0);
    lit("nowrite_fwd_a", fwd_a_sel, 0);
    nops(3);

    // Producer aged into WB: writeback-hold path.
    issue(0, 0, 0, 0, 13, 1, 0, st);
    nops(2);
    issue(13, 1, 0, 0, 19, 1, 0, st);
    lit("wb_stalls", st, FWD ? 0 : 1);
    lit("wb_fwd_a", fwd_a_sel, FWD ? 3 : 0);
    nops(3);

    // Reset in the middle of a load-use stall.
    issue(0, 0, 0, 0, 3, 1, 1, st);
    drive(1, 3, 1, 0, 0, 20, 1, 0);
    @(negedge clk);
    lit("rst_pre_stall", stall, 1);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    lit("rst_post_stall", stall, 0);
    lit("rst_post_fwd_a", fwd_a_sel, 0);
    issue(3, 1, 0, 0, 20, 1, 0, st);
    lit("rst_post_issue_stalls", st, 0);
    nops(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
